// File: rtl/codec_i2c_sequencer.sv
// ============================================================================
// Module      : codec_i2c_sequencer
// Description : Writes a table of 16-bit codec register entries (or a single
//               runtime entry) over an open-drain I2C bus, three bytes per
//               frame, with per-frame NACK retry and sticky error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module codec_i2c_sequencer #(
  parameter int         CLK_DIV     = 125,
  parameter int         NUM_REGS    = 9,
  parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
  parameter int         MAX_RETRIES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_REGS*16-1:0] cfg_table,
  input  logic                  wr_req,
  input  logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_error,
  output logic [5:0]            err_index,
  inout  wire                   i2c_data,
  output logic                  i2c_clk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BYTE  = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   tick_cnt_q;
  logic [1:0]         quarter_q;
  logic [2:0]         bit_q;
  logic [1:0]         byte_q;
  logic [7:0]         shift_q;
  logic [15:0]        entry_q;
  logic [5:0]         idx_q;
  logic [RTY_W-1:0]   retry_q;
  logic               seq_q;
  logic               nack_q;
  logic               ack_bit_q;
  logic               sda_meta_q;
  logic               sda_sync_q;
  logic               busy_q;
  logic               done_q;
  logic               ack_error_q;
  logic [5:0]         err_index_q;
  logic               scl_q;
  logic               sda_oe_q;

  logic               tick;
  logic [5:0]         sel_idx;
  logic [15:0]        tbl_entry;
  logic               sda_d;
  logic               scl_d;

  assign tick      = busy_q && (tick_cnt_q == DIV_W'(CLK_DIV - 1));
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;
  assign err_index = err_index_q;
  assign i2c_clk   = scl_q;
  // Open drain: only ever pull low, otherwise release.
  assign i2c_data  = sda_oe_q ? 1'b0 : 1'bz;

  // Quarter-bit tick divider, frozen at zero while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (!busy_q || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + DIV_W'(1);
    end
  end

  // Two-flop synchronizer for the slave's ACK bit on SDA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= i2c_data;
      sda_sync_q <= sda_meta_q;
    end
  end

  // Table entry to latch: entry 0 on accept, otherwise the following entry.
  always_comb begin
    sel_idx   = (state_q == S_IDLE) ? 6'd0 : idx_q + 6'd1;
    tbl_entry = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (sel_idx == 6'(k)) tbl_entry = cfg_table[k*16 +: 16];
    end
  end

  // Bus levels for the current slot and quarter (registered one cycle later).
  always_comb begin
    sda_d = 1'b1;
    scl_d = 1'b1;
    case (state_q)
      S_START: sda_d = ~quarter_q[1];
      S_BYTE: begin
        scl_d = quarter_q[1];
        sda_d = shift_q[7];
      end
      S_ACK:   scl_d = quarter_q[1];
      S_STOP: begin
        scl_d = (quarter_q != 2'd0);
        sda_d = quarter_q[1];
      end
      default: ;
    endcase
  end

  // Frame sequencer: request accept, slot/quarter stepping, retry and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      quarter_q   <= 2'd0;
      bit_q       <= 3'd0;
      byte_q      <= 2'd0;
      shift_q     <= 8'hFF;
      entry_q     <= 16'h0000;
      idx_q       <= 6'd0;
      retry_q     <= '0;
      seq_q       <= 1'b0;
      nack_q      <= 1'b0;
      ack_bit_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      err_index_q <= 6'd0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      scl_q    <= scl_d;
      sda_oe_q <= ~sda_d;
      if (state_q == S_IDLE) begin
        if (start || wr_req) begin
          busy_q      <= 1'b1;
          ack_error_q <= 1'b0;
          err_index_q <= 6'd0;
          idx_q       <= 6'd0;
          retry_q     <= '0;
          seq_q       <= start;
          entry_q     <= start ? tbl_entry : wr_data;
          quarter_q   <= 2'd0;
          state_q     <= S_START;
        end
      end else if (tick) begin
        quarter_q <= quarter_q + 2'd1;
        case (state_q)
          S_START: begin
            if (quarter_q == 2'd3) begin
              shift_q <= {SLAVE_ADDR, 1'b0};
              bit_q   <= 3'd0;
              byte_q  <= 2'd0;
              state_q <= S_BYTE;
            end
          end
          S_BYTE: begin
            if (quarter_q == 2'd3) begin
              if (bit_q == 3'd7) begin
                state_q <= S_ACK;
              end else begin
                bit_q   <= bit_q + 3'd1;
                shift_q <= {shift_q[6:0], 1'b0};
              end
            end
          end
          S_ACK: begin
            if (quarter_q == 2'd2) ack_bit_q <= sda_sync_q;
            if (quarter_q == 2'd3) begin
              // A NACK skips the rest of the frame.
              if (ack_bit_q || byte_q == 2'd2) begin
                nack_q  <= ack_bit_q;
                state_q <= S_STOP;
              end else begin
                byte_q  <= byte_q + 2'd1;
                bit_q   <= 3'd0;
                shift_q <= (byte_q == 2'd0) ? entry_q[15:8] : entry_q[7:0];
                state_q <= S_BYTE;
              end
            end
          end
          S_STOP: begin
            if (quarter_q == 2'd3) state_q <= S_GAP;
          end
          S_GAP: begin
            if (quarter_q == 2'd3) begin
              if (nack_q) begin
                if (retry_q < RTY_W'(MAX_RETRIES)) begin
                  retry_q <= retry_q + RTY_W'(1);
                  state_q <= S_START;
                end else begin
                  ack_error_q <= 1'b1;
                  err_index_q <= idx_q;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= S_IDLE;
                end
              end else begin
                retry_q <= '0;
                if (seq_q && idx_q < 6'(NUM_REGS - 1)) begin
                  idx_q   <= idx_q + 6'd1;
                  entry_q <= tbl_entry;
                  state_q <= S_START;
                end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
